// File: rtl/pred_acc_cpu_pkg.sv
// Shared definitions for the predicated accumulator CPU: field enums, field
// offsets inside the control slice, the instruction decoder and the predicate.
// Instruction layout (MSB..LSB): if_flag, if_not_flag, set_flag, op[2], src[2], wb[3], imm[WORD_W].
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_ANS = 2'd1,
    SRC_IN  = 2'd2,
    SRC_ACC = 2'd3
  } src_e;

  // Encodings 5-7 are legal in the instruction word and mean "no writeback".
  typedef enum logic [2:0] {
    WB_NON = 3'd0,
    WB_ACC = 3'd1,
    WB_ANS = 3'd2,
    WB_OUT = 3'd3,
    WB_JMP = 3'd4
  } wb_e;

  // Control slice sits directly above the immediate; offsets are relative to it.
  localparam int CTL_W           = 10;
  localparam int CTL_WB_LSB      = 0;
  localparam int CTL_SRC_LSB     = 3;
  localparam int CTL_OP_LSB      = 5;
  localparam int CTL_SET_FLAG    = 7;
  localparam int CTL_IF_NOT_FLAG = 8;
  localparam int CTL_IF_FLAG     = 9;

  // Widest datapath the decoder handles; callers zero-extend their word.
  localparam int MAX_WORD_W  = 64;
  localparam int MAX_INSTR_W = CTL_W + MAX_WORD_W;

  typedef struct packed {
    logic                  exec_if_flag;
    logic                  exec_if_not_flag;
    logic                  set_flag;
    alu_op_e               op;
    src_e                  src;
    logic [2:0]            wb;
    logic [MAX_WORD_W-1:0] imm;
  } instr_t;

  // word_w is an elaboration constant at every call site, so the shifts
  // collapse to plain wiring.
  function automatic instr_t decode(input logic [MAX_INSTR_W-1:0] instr,
                                    input int unsigned word_w);
    instr_t                 f;
    logic [MAX_INSTR_W-1:0] shifted;
    logic [CTL_W-1:0]       ctl;
    shifted            = instr >> word_w;
    ctl                = shifted[CTL_W-1:0];
    f.exec_if_flag     = ctl[CTL_IF_FLAG];
    f.exec_if_not_flag = ctl[CTL_IF_NOT_FLAG];
    f.set_flag         = ctl[CTL_SET_FLAG];
    f.op               = alu_op_e'(ctl[CTL_OP_LSB +: 2]);
    f.src              = src_e'(ctl[CTL_SRC_LSB +: 2]);
    f.wb               = ctl[CTL_WB_LSB +: 3];
    f.imm              = MAX_WORD_W'(instr & ~({MAX_INSTR_W{1'b1}} << word_w));
    return f;
  endfunction

  // Both predicate bits set can never be satisfied, which gives a free NOP.
  function automatic logic pred_exec(input logic if_flag, input logic if_not_flag,
                                     input logic flag);
    return (!if_flag || flag) && (!if_not_flag || !flag);
  endfunction

endpackage

// File: rtl/pred_acc_cpu_if.sv
// Program-load and port-handshake bundle for pred_acc_cpu.
// slave: the core (consumes prog/in, produces out); master: the surrounding system.
// Signals: prog_we/prog_addr/prog_data, in_data/in_valid/in_ready, out_data/out_valid/out_ready.
interface pred_acc_cpu_if
  import cpu_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int ROM_DEPTH = 8
);
  localparam int AW      = $clog2(ROM_DEPTH);
  localparam int INSTR_W = CTL_W + WORD_W;

  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;

  logic [WORD_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;

  logic [WORD_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output prog_we, prog_addr, prog_data, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/pred_acc_cpu_alu.sv
// Combinational WORD_W-bit ALU: a, b, op -> result plus a per-op status flag.
// Ports: a_i, b_i operands; op_i operation; result_o WORD_W result; flag_o status.
// Flag: ADD carry, SUB borrow, XOR equality, PASS b==0. Zero latency, no backpressure.
module alu_w
  import cpu_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [WORD_W-1:0] result_o,
  output logic              flag_o
);

  logic [WORD_W:0] sum;
  assign sum = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[WORD_W-1:0];
        flag_o   = sum[WORD_W];
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        flag_o   = (a_i < b_i);
      end
      OP_XOR: begin
        result_o = a_i ^ b_i;
        flag_o   = (a_i == b_i);
      end
      OP_PASS: begin
        result_o = b_i;
        flag_o   = (b_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pred_acc_cpu.sv
// Single-issue predicated accumulator CPU with writable program memory.
// Latency: one instruction per cycle; memory writes visible to fetch the cycle after.
// Backpressure: an executing instruction stalls (pc frozen) until its input/output port handshake can complete.
// Ports: clk, rst (sync, active high), run (execute enable), bus (prog load + in/out
// handshakes), pc (program counter), flag (flag register), stall (blocked by a port).
module pred_acc_cpu
  import cpu_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int ROM_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  pred_acc_cpu_if.slave                bus,
  output logic [$clog2(ROM_DEPTH)-1:0] pc,
  output logic                         flag,
  output logic                         stall
);

  localparam int AW      = $clog2(ROM_DEPTH);
  localparam int INSTR_W = CTL_W + WORD_W;

  logic [INSTR_W-1:0] mem_q [ROM_DEPTH];

  logic [AW-1:0]     pc_q, pc_d, pc_inc;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] ans_q, ans_d;
  logic              flag_q, flag_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [INSTR_W-1:0] instr;
  instr_t             dec;
  logic [WORD_W-1:0]  imm;
  logic [WORD_W-1:0]  alu_b;
  logic [WORD_W-1:0]  alu_res;
  logic               alu_flag;
  logic               exec, in_ok, out_ok, step;
  logic               unused_imm_hi;

  // Program memory: no reset, written whenever prog_we is high.
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign instr         = mem_q[pc_q];
  assign dec           = decode(MAX_INSTR_W'(instr), WORD_W);
  assign imm           = dec.imm[WORD_W-1:0];
  assign unused_imm_hi = ^(dec.imm >> WORD_W);

  assign exec   = pred_exec(dec.exec_if_flag, dec.exec_if_not_flag, flag_q);
  assign pc_inc = pc_q + AW'(1);

  always_comb begin
    alu_b = imm;
    case (dec.src)
      SRC_IMM: alu_b = imm;
      SRC_ANS: alu_b = ans_q;
      SRC_IN:  alu_b = bus.in_data;
      SRC_ACC: alu_b = acc_q;
      default: ;
    endcase
  end

  alu_w #(.WORD_W(WORD_W)) u_alu (
    .a_i      (acc_q),
    .b_i      (alu_b),
    .op_i     (dec.op),
    .result_o (alu_res),
    .flag_o   (alu_flag)
  );

  // The output slot is free if empty or being drained this very cycle.
  assign in_ok  = (dec.src != SRC_IN) || bus.in_valid;
  assign out_ok = (dec.wb != WB_OUT) || !out_valid_q || bus.out_ready;
  assign step   = in_ok && out_ok;

  // in_ready also waits for out_ok so input is only taken when the instruction
  // retires. Nothing handshakes during the reset cycle.
  assign bus.in_ready  = !rst && run && exec && (dec.src == SRC_IN) && out_ok;
  assign stall         = !rst && run && exec && !step;
  assign bus.out_valid = out_valid_q && !rst;
  assign bus.out_data  = out_data_q;
  assign pc            = pc_q;
  assign flag          = flag_q;

  always_comb begin
    pc_d        = pc_q;
    acc_d       = acc_q;
    ans_d       = ans_q;
    flag_d      = flag_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Draining is independent of run; a same-cycle OUT write below overrides.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (run && !exec) begin
      pc_d = pc_inc;
    end else if (run && step) begin
      pc_d = (dec.wb == WB_JMP) ? alu_res[AW-1:0] : pc_inc;
      case (dec.wb)
        WB_ACC: acc_d = alu_res;
        WB_ANS: ans_d = alu_res;
        WB_OUT: begin
          out_data_d  = alu_res;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
      if (dec.set_flag) begin
        flag_d = alu_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      acc_q       <= '0;
      ans_q       <= '0;
      flag_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      ans_q       <= ans_d;
      flag_q      <= flag_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pred_acc_cpu.sv
// Directed bench for pred_acc_cpu: hand-encoded programs, hand-computed results.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or 1 ns after an input change for combinational handshake outputs).
module tb_pred_acc_cpu;

  localparam int WORD_W    = 8;
  localparam int ROM_DEPTH = 8;
  localparam int AW        = 3;
  localparam int INSTR_W   = 18;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, XOR = 2'd2, PASS = 2'd3;
  localparam logic [1:0] IMM = 2'd0, ANS = 2'd1, IN = 2'd2, ACC = 2'd3;
  localparam logic [2:0] NON = 3'd0, WACC = 3'd1, WANS = 3'd2, OUT = 3'd3, JMP = 3'd4;

  logic          clk;
  logic          rst;
  logic          run;
  logic [AW-1:0] pc;
  logic          flag;
  logic          stall;

  int checks;
  int errors;

  pred_acc_cpu_if #(.WORD_W(WORD_W), .ROM_DEPTH(ROM_DEPTH)) bus ();

  pred_acc_cpu #(.WORD_W(WORD_W), .ROM_DEPTH(ROM_DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .bus   (bus),
    .pc    (pc),
    .flag  (flag),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [INSTR_W-1:0] enc(input logic pf, input logic pn, input logic sf,
                                             input logic [1:0] op, input logic [1:0] src,
                                             input logic [2:0] wb, input logic [7:0] imm);
    return {pf, pn, sf, op, src, wb, imm};
  endfunction

  logic [INSTR_W-1:0] nop;
  assign nop = enc(1'b1, 1'b1, 1'b0, ADD, IMM, NON, 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input int a, input logic [INSTR_W-1:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(a);
    bus.prog_data = d;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < ROM_DEPTH; i++) prog(i, nop);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_a[7];
    int exp_b[7];
    checks = 0;
    errors = 0;
    rst = 1'b1;
    run = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flag", 32'(flag), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);

    // 1: acc = 5; out = acc + acc = 0x0A at cycle 2
    clear_prog();
    prog(0, enc(0, 0, 0, ADD, IMM, WACC, 8'h05));
    prog(1, enc(0, 0, 0, ADD, ACC, OUT, 8'h00));
    bus.out_ready = 1'b1;
    run = 1'b1;
    @(negedge clk);
    chk("s1_pc1", 32'(pc), 1);
    chk("s1_ov_c1", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("s1_out_data", 32'(bus.out_data), 32'h0A);
    chk("s1_out_valid", 32'(bus.out_valid), 1);
    chk("s1_pc2", 32'(pc), 2);
    run = 1'b0;
    @(negedge clk);
    chk("s1_drain_run0", 32'(bus.out_valid), 0);
    chk("s1_pc_hold", 32'(pc), 2);

    // 2: FF + 1 -> acc 0, carry flag; if_not_flag skipped; out = acc ^ 5A
    do_reset();
    clear_prog();
    prog(0, enc(0, 0, 0, PASS, IMM, WACC, 8'hFF));
    prog(1, enc(0, 0, 1, ADD, IMM, WACC, 8'h01));
    prog(2, enc(0, 1, 0, PASS, IMM, WACC, 8'h33));
    prog(3, enc(0, 0, 0, XOR, IMM, OUT, 8'h5A));
    run = 1'b1;
    @(negedge clk);
    chk("s2_pc1", 32'(pc), 1);
    chk("s2_flag_c1", 32'(flag), 0);
    @(negedge clk);
    chk("s2_pc2", 32'(pc), 2);
    chk("s2_carry_flag", 32'(flag), 1);
    @(negedge clk);
    chk("s2_skip_pc3", 32'(pc), 3);
    chk("s2_skip_ov", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("s2_acc_via_out", 32'(bus.out_data), 32'h5A);
    chk("s2_out_valid", 32'(bus.out_valid), 1);
    chk("s2_pc4", 32'(pc), 4);
    chk("s2_flag_kept", 32'(flag), 1);
    run = 1'b0;
    @(negedge clk);

    // 7: SUB borrow into ANS, if_flag both ways, XOR equality, PASS zero test
    do_reset();
    clear_prog();
    prog(0, enc(0, 0, 0, PASS, IMM, WACC, 8'h03));
    prog(1, enc(0, 0, 1, SUB, IMM, WANS, 8'h05));
    prog(2, enc(1, 0, 0, PASS, ANS, OUT, 8'h00));
    prog(3, enc(0, 0, 1, XOR, IMM, NON, 8'h04));
    prog(4, enc(1, 0, 0, PASS, IMM, OUT, 8'h99));
    prog(5, enc(0, 1, 1, XOR, IMM, OUT, 8'h03));
    prog(6, enc(0, 0, 1, PASS, IMM, NON, 8'h07));
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("f_borrow_flag", 32'(flag), 1);
    chk("f_pc2", 32'(pc), 2);
    @(negedge clk);
    chk("f_ans_out", 32'(bus.out_data), 32'hFE);
    chk("f_ans_ov", 32'(bus.out_valid), 1);
    @(negedge clk);
    chk("f_xor_ne_flag", 32'(flag), 0);
    chk("f_drain_ov", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("f_if_flag_skip_pc", 32'(pc), 5);
    chk("f_if_flag_skip_ov", 32'(bus.out_valid), 0);
    chk("f_if_flag_skip_data", 32'(bus.out_data), 32'hFE);
    @(negedge clk);
    chk("f_xor_out", 32'(bus.out_data), 32'h00);
    chk("f_xor_ov", 32'(bus.out_valid), 1);
    chk("f_xor_eq_flag", 32'(flag), 1);
    @(negedge clk);
    chk("f_pass_nz_flag", 32'(flag), 0);
    chk("f_pc7", 32'(pc), 7);
    run = 1'b0;

    // 3: jump loop 1..3, write to the fetched word, then wrap 7 -> 0
    do_reset();
    clear_prog();
    prog(3, enc(0, 0, 0, PASS, IMM, JMP, 8'h01));
    chk("s3_pc0", 32'(pc), 0);
    exp_a = '{1, 2, 3, 1, 2, 3, 1};
    exp_b = '{2, 3, 4, 5, 6, 7, 0};
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("s3_jmp_pc%0d", i), 32'(pc), 32'(exp_a[i]));
    end
    @(negedge clk);
    chk("s3_pc_a", 32'(pc), 2);
    @(negedge clk);
    chk("s3_pc_b", 32'(pc), 3);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'd3;
    bus.prog_data = nop;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    chk("s3_old_word_jumps", 32'(pc), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("s3_wrap_pc%0d", i), 32'(pc), 32'(exp_b[i]));
    end
    run = 1'b0;

    // 4: input stall, then a single handshake of 0x22
    do_reset();
    clear_prog();
    prog(0, enc(0, 0, 0, ADD, IN, WACC, 8'h00));
    prog(1, enc(0, 0, 0, PASS, ACC, OUT, 8'h00));
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("s4_pc_stall%0d", i), 32'(pc), 0);
      chk($sformatf("s4_stall%0d", i), 32'(stall), 1);
      chk($sformatf("s4_in_ready%0d", i), 32'(bus.in_ready), 1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    #1;
    chk("s4_stall_release", 32'(stall), 0);
    chk("s4_in_ready_hs", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("s4_pc1", 32'(pc), 1);
    chk("s4_in_ready_after", 32'(bus.in_ready), 0);
    chk("s4_stall_after", 32'(stall), 0);
    @(negedge clk);
    chk("s4_acc_via_out", 32'(bus.out_data), 32'h22);
    chk("s4_out_valid", 32'(bus.out_valid), 1);
    chk("s4_pc2", 32'(pc), 2);
    run = 1'b0;
    @(negedge clk);

    // 5: back-to-back OUT with consumer blocked, then accept+refill same cycle
    do_reset();
    clear_prog();
    prog(0, enc(0, 0, 0, PASS, IMM, OUT, 8'h11));
    prog(1, enc(0, 0, 0, PASS, IMM, OUT, 8'h22));
    bus.out_ready = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("s5_ov_first", 32'(bus.out_valid), 1);
    chk("s5_data_first", 32'(bus.out_data), 32'h11);
    chk("s5_pc1", 32'(pc), 1);
    chk("s5_stall", 32'(stall), 1);
    @(negedge clk);
    chk("s5_pc_frozen", 32'(pc), 1);
    chk("s5_data_held", 32'(bus.out_data), 32'h11);
    chk("s5_stall_held", 32'(stall), 1);
    bus.out_ready = 1'b1;
    #1;
    chk("s5_stall_release", 32'(stall), 0);
    @(negedge clk);
    chk("s5_ov_refill", 32'(bus.out_valid), 1);
    chk("s5_data_refill", 32'(bus.out_data), 32'h22);
    chk("s5_pc2", 32'(pc), 2);
    @(negedge clk);
    chk("s5_ov_drained", 32'(bus.out_valid), 0);
    chk("s5_pc3", 32'(pc), 3);
    run = 1'b0;

    // 6: reset during an input stall with a pending output
    do_reset();
    clear_prog();
    prog(0, enc(0, 0, 0, PASS, IMM, OUT, 8'h44));
    prog(1, enc(0, 0, 0, ADD, IN, WACC, 8'h00));
    prog(2, enc(0, 0, 0, PASS, ACC, OUT, 8'h00));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("s6_pending_ov", 32'(bus.out_valid), 1);
    chk("s6_pc1", 32'(pc), 1);
    chk("s6_stall", 32'(stall), 1);
    chk("s6_in_ready", 32'(bus.in_ready), 1);
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = 1'b1;
    #1;
    chk("s6_rst_in_ready", 32'(bus.in_ready), 0);
    chk("s6_rst_stall", 32'(stall), 0);
    chk("s6_rst_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_data = 8'h07;
    #1;
    chk("s6_pc0", 32'(pc), 0);
    chk("s6_flag0", 32'(flag), 0);
    chk("s6_ov0", 32'(bus.out_valid), 0);
    chk("s6_od0", 32'(bus.out_data), 0);
    chk("s6_in_ready_pc0", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("s6_rerun_data", 32'(bus.out_data), 32'h44);
    chk("s6_rerun_ov", 32'(bus.out_valid), 1);
    chk("s6_rerun_pc1", 32'(pc), 1);
    chk("s6_rerun_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("s6_drained", 32'(bus.out_valid), 0);
    chk("s6_pc2", 32'(pc), 2);
    @(negedge clk);
    chk("s6_acc_via_out", 32'(bus.out_data), 32'h07);
    chk("s6_ov_final", 32'(bus.out_valid), 1);
    chk("s6_pc3", 32'(pc), 3);
    run = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_acc_cpu.md
Name: pred_acc_cpu

Overview:
Parametrised single-issue accumulator CPU that generalises the existing rom/alu/port trio into a working core.
- Writable program memory fetched by a program counter, with predicated execution against a flag register.
- ALU result writeback to the accumulator, the answer register, the output port or the PC (jump).
- Valid/ready handshakes on the input and output ports, which stall the core.
- One instruction per cycle when not stalled.

Parameters:
WORD_W, 8, datapath width (acc, ans, imm, port data).
ROM_DEPTH, 8, program words; power of two, >=2; AW = $clog2(ROM_DEPTH).
INSTR_W, 10+WORD_W, derived; not overridable.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
run  in  1  execute enable; 0 freezes all architectural state
prog_we  in  1  program memory write strobe
prog_addr  in  AW  program write address
prog_data  in  INSTR_W  program write data
in_data  in  WORD_W  input port data
in_valid  in  1  input data available
in_ready  out  1  core consumes in_data this cycle
out_data  out  WORD_W  output port data, registered
out_valid  out  1  out_data pending
out_ready  in  1  consumer accepts out_data
pc  out  AW  current program counter
flag  out  1  flag register
stall  out  1  run high but instruction blocked by a port

Behaviour:
- Instruction fields, MSB to LSB:
  - exec_if_flag[1], exec_if_not_flag[1], set_flag[1]
  - op[2]: ADD=0, SUB=1, XOR=2, PASS=3
  - src[2]: IMM=0, ANS=1, IN=2, ACC=3
  - wb[3]: NON=0, ACC=1, ANS=2, OUT=3, JMP=4; values 5-7 behave as NON
  - imm[WORD_W]
- Predicate:
  - Both predicate bits 0: always execute.
  - if_flag only: execute when flag=1.
  - if_not_flag only: execute when flag=0.
  - Both 1: never execute (NOP).
- ALU operands: a=acc; b selected by src. Result is WORD_W bits, plus alu_flag:
  - ADD: carry out of a+b.
  - SUB: borrow (a<b unsigned).
  - XOR: a==b.
  - PASS: result=b, flag=(b==0).
- Fetch: combinational read of mem[pc].
- Memory writes are registered. A write to the address being fetched in the same cycle takes effect next cycle; the current cycle executes the old word.
- Memory is not cleared by rst. prog_we is honoured during rst and while run=0.
- Step conditions (run=1, instruction executing):
  - in_ok = (src!=IN) | in_valid.
  - out_ok = (wb!=OUT) | !out_valid | out_ready.
  - step = in_ok & out_ok.
  - in_ready = run & exec & src==IN & out_ok. Input is never consumed without the instruction completing.
  - stall = run & exec & !step.
- A non-executing (predicated-off) instruction always steps: pc+1, no other state change, no handshake.
- On step:
  - pc <= (wb==JMP) ? result[AW-1:0] : pc+1. pc wraps ROM_DEPTH-1 -> 0.
  - wb ACC/ANS: load that register.
  - wb OUT: out_data <= result, out_valid <= 1.
  - If set_flag: flag <= alu_flag.
- Output buffer (one entry):
  - out_valid & out_ready with no new OUT write: out_valid <= 0 next cycle.
  - Simultaneous accept and new OUT write: out_valid stays 1 with new data.
  - out_valid/out_data change only via handshake or step. They are independent of run while draining.
- run=0: pc, acc, ans and flag hold; in_ready=0; stall=0; a pending output still drains.
- Reset values: pc=0, acc=0, ans=0, flag=0, out_valid=0, out_data=0. in_ready and stall evaluate from the reset state.
- Reset mid-stall or with a pending output discards both; nothing is handshaked in the rst cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - enums alu_op_e, src_e, wb_e
  - field-offset localparams
  - function decode(instr) returning the fields for a given WORD_W
- One sub-module, alu_w #(WORD_W): combinational a, b, op -> result, alu_flag. It succeeds the fixed 8-bit alu.

Test Plan:
1. ROM_DEPTH=8: mem0=ADD IMM 5 wb ACC; mem1=ADD ACC wb OUT; run=1, out_ready=1 -> cycle 2: out_data=0x0A, out_valid=1, pc=2.
2. mem0=PASS IMM 0xFF wb ACC; mem1=ADD IMM 1 set_flag wb ACC; mem2=if_not_flag PASS IMM 0x33 wb ACC -> acc=0x00, flag=1, mem2 skipped, acc stays 0x00, pc=3.
3. mem3=PASS IMM 1 wb JMP -> pc sequence 0,1,2,3,1,2,3,1; wrap check with 8 NOPs -> pc 7 then 0.
4. mem0=ADD IN wb ACC, in_valid=0 for 3 cycles -> pc=0, stall=1, in_ready=1; then in_valid=1, in_data=0x22 -> one handshake, acc=0x22, pc=1.
5. Two consecutive OUT instructions (0x11, 0x22), out_ready=0 -> first out_valid=1 data 0x11, second stalls with pc frozen; out_ready=1 -> 0x11 accepted and 0x22 loaded the same cycle; next cycle 0x22 accepted, out_valid=0.
6. rst asserted during the scenario-4 stall with in_valid=1 -> no in_ready that cycle; after reset pc=0, acc=0, out_valid=0; mem contents unchanged and re-executable.
